// File: rtl/dram_piso.sv
// Parallel-in/serial-out transmit stage: MSB-first shifter with a one-entry holding register.
// Optional even-parity trailer bit is enabled by defining DRAM_PISO_PARITY_EN.
module dram_piso #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned GAP   = 0
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned GAP_W = 4;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_TOP = GAP_W'((GAP == 0) ? 0 : GAP - 1);

`ifdef DRAM_PISO_PARITY_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PAR, S_GAP} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_e;
`endif

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [WIDTH-1:0]   hold_q, hold_d;
  logic               hold_full_q, hold_full_d;
  logic               ser_out_q, ser_out_d;
  logic               ser_valid_q, ser_valid_d;
  logic               ser_first_q, ser_first_d;
  logic               ser_last_q, ser_last_d;
  logic               busy_q, busy_d;
`ifdef DRAM_PISO_PARITY_EN
  logic               par_q, par_d;
`endif

  logic               accept;
  logic               slot_end;
  logic               bypass;
  logic               load;
  logic [WIDTH-1:0]   load_w;

  assign accept = in_valid && !hold_full_q;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_first_q <= 1'b0;
      ser_last_q  <= 1'b0;
      busy_q      <= 1'b0;
`ifdef DRAM_PISO_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      ser_first_q <= ser_first_d;
      ser_last_q  <= ser_last_d;
      busy_q      <= busy_d;
`ifdef DRAM_PISO_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  // Next-state, reload arbitration and next-cycle output values.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
`ifdef DRAM_PISO_PARITY_EN
    par_d       = par_q;
`endif
    slot_end    = 1'b0;
    bypass      = 1'b0;
    load        = 1'b0;
    load_w      = hold_q;

    case (state_q)
      S_IDLE: slot_end = 1'b1;
      S_SHIFT: begin
        if (bit_cnt_q != '0) begin
          shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q - CNT_W'(1);
        end else begin
`ifdef DRAM_PISO_PARITY_EN
          state_d = S_PAR;
`else
          if (GAP != 0) begin
            state_d   = S_GAP;
            gap_cnt_d = GAP_TOP;
          end else begin
            slot_end = 1'b1;
          end
`endif
        end
      end
`ifdef DRAM_PISO_PARITY_EN
      S_PAR: begin
        if (GAP != 0) begin
          state_d   = S_GAP;
          gap_cnt_d = GAP_TOP;
        end else begin
          slot_end = 1'b1;
        end
      end
`endif
      S_GAP: begin
        if (gap_cnt_q == '0) slot_end = 1'b1;
        else gap_cnt_d = gap_cnt_q - GAP_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    // A finished slot takes the held word first, then a bypassing input word.
    if (slot_end) begin
      if (hold_full_q) begin
        load        = 1'b1;
        load_w      = hold_q;
        hold_full_d = 1'b0;
      end else if (accept) begin
        load   = 1'b1;
        load_w = in_data;
        bypass = 1'b1;
      end else begin
        state_d = S_IDLE;
      end
    end

    if (load) begin
      state_d   = S_SHIFT;
      shreg_d   = load_w;
      bit_cnt_d = CNT_TOP;
`ifdef DRAM_PISO_PARITY_EN
      par_d     = ^load_w;
`endif
    end

    if (accept && !bypass) begin
      hold_d      = in_data;
      hold_full_d = 1'b1;
    end

    ser_valid_d = (state_d == S_SHIFT);
    ser_out_d   = (state_d == S_SHIFT) && shreg_d[WIDTH-1];
    ser_first_d = (state_d == S_SHIFT) && (bit_cnt_d == CNT_TOP);
`ifdef DRAM_PISO_PARITY_EN
    ser_valid_d = ser_valid_d || (state_d == S_PAR);
    ser_out_d   = ser_out_d || ((state_d == S_PAR) && par_d);
    ser_last_d  = (state_d == S_PAR);
`else
    ser_last_d  = (state_d == S_SHIFT) && (bit_cnt_d == '0);
`endif
    busy_d      = (state_d != S_IDLE) || hold_full_d;
  end

  assign in_ready  = !hold_full_q;
  assign ser_out   = ser_out_q;
  assign ser_valid = ser_valid_q;
  assign ser_first = ser_first_q;
  assign ser_last  = ser_last_q;
  assign busy      = busy_q;

endmodule
